// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: LFSR pattern generator and 8-bit MISR compactor that runs a BIST pass over the c17 netlist.
// Optional golden-signature compare with a pass output is enabled by defining C17_BIST_GOLDEN_EN.
module c17_bist_ctrl #(
    parameter int         NUM_PATTERNS = 31,
    parameter logic [4:0] LFSR_SEED    = 5'h01,
    parameter logic [7:0] MISR_SEED    = 8'h00
`ifdef C17_BIST_GOLDEN_EN
    ,
    parameter logic [7:0] GOLDEN_SIG   = 8'h00
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] test,
    output logic       nx2,
    output logic       nx6,
    input  logic       nx22,
    input  logic       nx23,
    output logic       busy,
    output logic       done,
`ifdef C17_BIST_GOLDEN_EN
    output logic       pass,
`endif
    output logic [7:0] signature
);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 31) begin : g_bad_num_patterns
        $error("c17_bist_ctrl: NUM_PATTERNS must be in 1..31");
    end
    if (LFSR_SEED == 5'h00) begin : g_bad_lfsr_seed
        $error("c17_bist_ctrl: LFSR_SEED must be nonzero");
    end

    localparam logic [4:0] LAST = 5'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_lfsr;
    logic [4:0] r_count;
    logic [4:0] r_pat;
    logic [7:0] r_sig;
    logic [4:0] w_lfsr_next;
    logic [7:0] w_sig_next;
    logic       w_last;

    assign w_lfsr_next = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
    assign w_sig_next  = {r_sig[6:4], r_sig[3] ^ r_sig[7], r_sig[2] ^ r_sig[7],
                          r_sig[1] ^ r_sig[7], r_sig[0] ^ nx23, r_sig[7] ^ nx22};
    assign w_last      = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // r_pat mirrors r_lfsr while running and is cleared on the final edge so DONE/IDLE present zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= LFSR_SEED;
            r_count <= '0;
            r_sig   <= MISR_SEED;
            r_pat   <= '0;
        end else if (r_state == IDLE && start) begin
            r_lfsr  <= LFSR_SEED;
            r_count <= '0;
            r_sig   <= MISR_SEED;
            r_pat   <= LFSR_SEED;
        end else if (r_state == RUN) begin
            r_lfsr  <= w_lfsr_next;
            r_count <= r_count + 5'd1;
            r_sig   <= w_sig_next;
            r_pat   <= w_last ? 5'h00 : w_lfsr_next;
        end
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
`ifdef C17_BIST_GOLDEN_EN
        pass = (r_state == DONE) && (r_sig == GOLDEN_SIG);
`endif
    end

    assign test      = r_pat[4:2];
    assign nx2       = r_pat[1];
    assign nx6       = r_pat[0];
    assign signature = r_sig;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb_c17_bist_ctrl: randomized responses and start noise checked against a queue-free arithmetic model of the BIST run.
module tb_c17_bist_ctrl;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic       nx22 = 0;
    logic       nx23 = 0;
    logic [2:0] test;
    logic       nx2, nx6, busy, done;
    logic [7:0] signature;
    logic       start2 = 0;
    logic [2:0] test2;
    logic       nx2_2, nx6_2, busy2, done2;
    logic [7:0] sig2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    c17_bist_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .test(test), .nx2(nx2), .nx6(nx6),
        .nx22(nx22), .nx23(nx23), .busy(busy), .done(done), .signature(signature)
    );

    c17_bist_ctrl #(.NUM_PATTERNS(2), .MISR_SEED(8'h00)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .test(test2), .nx2(nx2_2), .nx6(nx6_2),
        .nx22(1'b1), .nx23(1'b1), .busy(busy2), .done(done2), .signature(sig2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] lfsr_step(input logic [4:0] l);
        int v;
        v = int'(l);
        return 5'(((v * 2) % 32) + (((v >> 4) + (v >> 2)) % 2));
    endfunction

    // rotate left, fold in polynomial taps when the old MSB was set, then add the two response bits
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
        logic [7:0] rot;
        rot = {s[6:0], s[7]};
        return rot ^ (s[7] ? 8'h1C : 8'h00) ^ {6'b0, r};
    endfunction

    task automatic run(input int n, input int abort_at);
        logic [4:0] l = 5'h01;
        logic [7:0] s = 8'h00;
        logic [1:0] r;
        start = 1;
        tick;
        start = 0;
        for (int i = 0; i < n; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("pattern", {test, nx2, nx6}, l);
            r = 2'($urandom_range(0, 3));
            {nx23, nx22} = r;
            start = 1'($urandom_range(0, 1));
            if (i == abort_at) rst = 1;
            tick;
            start = 0;
            s = misr_step(s, r);
            l = lfsr_step(l);
            if (i == abort_at) begin
                rst = 0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_sig", signature, 8'h00);
                check("abort_pat", {test, nx2, nx6}, 0);
                tick;
                check("abort_nodone", done, 0);
                check("abort_idle", busy, 0);
                return;
            end
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("pat_done", {test, nx2, nx6}, 0);
        check("sig_done", signature, s);
        start = 1'($urandom_range(0, 1));
        tick;
        start = 0;
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("sig_hold", signature, s);
    endtask

    initial begin
        tick;
        tick;
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pat", {test, nx2, nx6}, 0);
        check("rst_sig", signature, 8'h00);
        start2 = 1;
        tick;
        start2 = 0;
        check("d2_busy", busy2, 1);
        check("d2_pat0", {test2, nx2_2, nx6_2}, 5'h01);
        tick;
        check("d2_sig1", sig2, 8'h03);
        check("d2_pat1", {test2, nx2_2, nx6_2}, 5'h02);
        tick;
        check("d2_done", done2, 1);
        check("d2_sig", sig2, 8'h05);
        tick;
        check("d2_idle", done2, 0);
        check("d2_hold", sig2, 8'h05);
        run(31, -1);
        run(31, -1);
        run(31, 9);
        run(31, int'($urandom_range(0, 30)));
        run(31, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
